// File: rtl/spoly_gen_ctrl_if.sv
// Bus bundle between the sparse-polynomial generator and its environment:
// random-word stream, working memory, external sorter and coefficient output.
interface spoly_gen_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
);
   logic [DATA_W-1:0] rnd_data;
   logic              rnd_valid;
   logic              rnd_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              sort_start;
   logic              sort_done;
   logic              coef_valid;
   logic [1:0]        coef_data;
   logic [ADDR_W-1:0] coef_idx;

   modport master (
      input  rnd_data, rnd_valid, mem_rdata, sort_done,
      output rnd_ready, mem_we, mem_addr, mem_wdata, sort_start,
             coef_valid, coef_data, coef_idx
   );

   modport slave (
      output rnd_data, rnd_valid, mem_rdata, sort_done,
      input  rnd_ready, mem_we, mem_addr, mem_wdata, sort_start,
             coef_valid, coef_data, coef_idx
   );
endinterface

// File: rtl/spoly_gen_ctrl.sv
// Fixed-weight ternary polynomial generator: tags random words into working memory,
// lets an external sorter shuffle them, then drains the tags as {-1,0,+1} coefficients.
module spoly_gen_ctrl #(
   parameter int P      = 677,
   parameter int W      = 254,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic done,
   output logic weight_ok,
   spoly_gen_ctrl_if.master bus
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int NZ_W  = $clog2(P + 1);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(P - 1);
   localparam logic [CNT_W-1:0] CNT_P     = CNT_W'(P);
   localparam logic [CNT_W-1:0] CNT_WGT   = CNT_W'(W);
   localparam logic [NZ_W-1:0]  NZ_TARGET = NZ_W'(W);
   localparam logic [NZ_W-1:0]  NZ_MAX    = NZ_W'(P);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FILL      = 3'd1,
      SORT_KICK = 3'd2,
      SORT_WAIT = 3'd3,
      DRAIN     = 3'd4,
      DONE      = 3'd5
   } state_t;

   // Tag decode: returns {illegal, coef}; code 11 never comes from FILL.
   function automatic logic [2:0] decode_coef(input logic [1:0] code);
      logic [2:0] res;
      case (code)
         2'b00:   res = {1'b0, 2'b11};
         2'b01:   res = {1'b0, 2'b00};
         2'b10:   res = {1'b0, 2'b01};
         default: res = {1'b1, 2'b00};
      endcase
      return res;
   endfunction

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [NZ_W-1:0]    nz_r;
   logic               ill_r;
   logic               busy_r;
   logic               done_r;
   logic               weight_ok_r;
   logic               rnd_ready_r;
   logic               mem_we_r;
   logic [ADDR_W-1:0]  mem_addr_r;
   logic [DATA_W-1:0]  mem_wdata_r;
   logic               sort_start_r;
   logic               coef_valid_r;
   logic [1:0]         coef_data_r;
   logic [ADDR_W-1:0]  coef_idx_r;

   logic               accept_s;
   logic [DATA_W-1:0]  fill_word_s;
   logic [2:0]         dec_s;
   logic [1:0]         dec_coef_s;
   logic               dec_ill_s;
   logic [NZ_W-1:0]    nz_next_s;
   logic               ill_next_s;
   logic               data_unused_s;

   // Fill tagging, read-back decode and next-count values for the last coefficient.
   always_comb begin
      accept_s    = bus.rnd_valid & rnd_ready_r;
      fill_word_s = {DATA_W{1'b0}};
      if (cnt_r < CNT_WGT) begin
         fill_word_s = {bus.rnd_data[DATA_W-1:1], 1'b0};
      end else begin
         fill_word_s = {bus.rnd_data[DATA_W-1:2], 2'b01};
      end
      dec_s      = decode_coef(bus.mem_rdata[1:0]);
      dec_coef_s = dec_s[1:0];
      dec_ill_s  = dec_s[2];
      nz_next_s  = nz_r;
      if ((dec_coef_s != 2'b00) && (nz_r != NZ_MAX)) begin
         nz_next_s = nz_r + NZ_W'(1);
      end else begin
         nz_next_s = nz_r;
      end
      ill_next_s    = ill_r | dec_ill_s;
      data_unused_s = ^{bus.mem_rdata[DATA_W-1:2], bus.rnd_data[0]};
   end

   // Main sequencer: state, counters and every registered output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         nz_r         <= {NZ_W{1'b0}};
         ill_r        <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         weight_ok_r  <= 1'b0;
         rnd_ready_r  <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= {ADDR_W{1'b0}};
         mem_wdata_r  <= {DATA_W{1'b0}};
         sort_start_r <= 1'b0;
         coef_valid_r <= 1'b0;
         coef_data_r  <= 2'b00;
         coef_idx_r   <= {ADDR_W{1'b0}};
      end else begin
         done_r       <= 1'b0;
         sort_start_r <= 1'b0;
         coef_valid_r <= 1'b0;
         mem_we_r     <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r     <= FILL;
                  busy_r      <= 1'b1;
                  rnd_ready_r <= 1'b1;
                  weight_ok_r <= 1'b0;
                  cnt_r       <= {CNT_W{1'b0}};
                  nz_r        <= {NZ_W{1'b0}};
                  ill_r       <= 1'b0;
                  mem_addr_r  <= {ADDR_W{1'b0}};
                  mem_wdata_r <= {DATA_W{1'b0}};
                  coef_data_r <= 2'b00;
                  coef_idx_r  <= {ADDR_W{1'b0}};
               end else begin
                  state_r <= IDLE;
               end
            end
            FILL: begin
               if (accept_s) begin
                  mem_we_r    <= 1'b1;
                  mem_addr_r  <= ADDR_W'(cnt_r);
                  mem_wdata_r <= fill_word_s;
                  if (cnt_r == CNT_LAST) begin
                     rnd_ready_r <= 1'b0;
                  end else begin
                     cnt_r <= cnt_r + CNT_W'(1);
                  end
               end else if (!rnd_ready_r) begin
                  // Ready already dropped, so the final write went out last cycle.
                  state_r      <= SORT_KICK;
                  sort_start_r <= 1'b1;
                  mem_addr_r   <= {ADDR_W{1'b0}};
                  mem_wdata_r  <= {DATA_W{1'b0}};
               end else begin
                  state_r <= FILL;
               end
            end
            SORT_KICK: begin
               state_r <= SORT_WAIT;
            end
            SORT_WAIT: begin
               if (bus.sort_done) begin
                  state_r    <= DRAIN;
                  cnt_r      <= {CNT_W{1'b0}};
                  mem_addr_r <= {ADDR_W{1'b0}};
               end else begin
                  state_r <= SORT_WAIT;
               end
            end
            DRAIN: begin
               cnt_r <= cnt_r + CNT_W'(1);
               // mem_rdata in drain cycle k belongs to the address issued in cycle k-1.
               if (cnt_r != {CNT_W{1'b0}}) begin
                  coef_valid_r <= 1'b1;
                  coef_idx_r   <= ADDR_W'(cnt_r - CNT_W'(1));
                  coef_data_r  <= dec_coef_s;
                  nz_r         <= nz_next_s;
                  ill_r        <= ill_next_s;
               end else begin
                  coef_valid_r <= 1'b0;
               end
               if (cnt_r < CNT_LAST) begin
                  mem_addr_r <= mem_addr_r + ADDR_W'(1);
               end else begin
                  mem_addr_r <= {ADDR_W{1'b0}};
               end
               if (cnt_r == CNT_P) begin
                  state_r     <= DONE;
                  done_r      <= 1'b1;
                  weight_ok_r <= (nz_next_s == NZ_TARGET) && !ill_next_s;
               end else begin
                  state_r <= DRAIN;
               end
            end
            DONE: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r     <= IDLE;
               busy_r      <= 1'b0;
               rnd_ready_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy           = busy_r;
   assign done           = done_r;
   assign weight_ok      = weight_ok_r;
   assign bus.rnd_ready  = rnd_ready_r;
   assign bus.mem_we     = mem_we_r;
   assign bus.mem_addr   = mem_addr_r;
   assign bus.mem_wdata  = mem_wdata_r;
   assign bus.sort_start = sort_start_r;
   assign bus.coef_valid = coef_valid_r;
   assign bus.coef_data  = coef_data_r;
   assign bus.coef_idx   = coef_idx_r;

endmodule

// File: tb/tb_spoly_gen_ctrl.sv
// Directed bench for spoly_gen_ctrl at P=8, W=3 with a 1-cycle-latency memory
// and a fixed-delay sorter that can plant one altered tag at address 4.
module tb_spoly_gen_ctrl;
   logic clk;
   logic rst;
   logic start;
   logic busy;
   logic done;
   logic weight_ok;

   spoly_gen_ctrl_if #(.DATA_W(32), .ADDR_W(10)) bus ();

   spoly_gen_ctrl #(.P(8), .W(3), .DATA_W(32), .ADDR_W(10)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .weight_ok(weight_ok), .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   logic        sorter_en;
   logic        corrupt_en;
   logic [1:0]  corrupt_val;
   logic        hold_start;
   logic        mon_clr;
   logic [31:0] rnd_tab [8];

   logic [31:0] mem [16];
   int          sd_cnt;

   int          wr_cnt, coef_cnt, sort_cnt, done_cnt, hs_cnt, align_err;
   logic        hs_prev;
   logic [9:0]  wr_addr  [16];
   logic [31:0] wr_data  [16];
   logic [1:0]  coef_arr [16];
   logic [9:0]  coef_seq [16];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory with registered read, plus a sorter that answers 3 cycles after sort_start.
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr[3:0]];
      if (rst) begin
         sd_cnt        <= 0;
         bus.sort_done <= 1'b0;
      end else if (bus.sort_start && sorter_en) begin
         sd_cnt        <= 3;
         bus.sort_done <= 1'b0;
         if (corrupt_en) mem[4] <= {mem[4][31:2], corrupt_val};
      end else if (sd_cnt != 0) begin
         sd_cnt        <= sd_cnt - 1;
         bus.sort_done <= (sd_cnt == 1);
      end else begin
         bus.sort_done <= 1'b0;
      end
   end

   // Event monitor sampled mid-cycle.
   always @(negedge clk) begin
      if (mon_clr) begin
         wr_cnt <= 0; coef_cnt <= 0; sort_cnt <= 0; done_cnt <= 0;
         hs_cnt <= 0; align_err <= 0; hs_prev <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            wr_addr[i]  <= 10'h3FF;
            wr_data[i]  <= 32'h0;
            coef_arr[i] <= 2'b10;
            coef_seq[i] <= 10'h3FF;
         end
      end else begin
         hs_prev <= bus.rnd_valid && bus.rnd_ready && !rst;
         if (bus.rnd_valid && bus.rnd_ready && !rst) hs_cnt <= hs_cnt + 1;
         if (bus.mem_we !== hs_prev) align_err <= align_err + 1;
         if (bus.mem_we) begin
            if (wr_cnt < 16) begin
               wr_addr[wr_cnt] <= bus.mem_addr;
               wr_data[wr_cnt] <= bus.mem_wdata;
            end
            wr_cnt <= wr_cnt + 1;
         end
         if (bus.coef_valid) begin
            coef_arr[bus.coef_idx[3:0]] <= bus.coef_data;
            if (coef_cnt < 16) coef_seq[coef_cnt] <= bus.coef_idx;
            coef_cnt <= coef_cnt + 1;
         end
         if (bus.sort_start) sort_cnt <= sort_cnt + 1;
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   task automatic clear_mon();
      mon_clr = 1'b1;
      @(negedge clk);
      #1;
      mon_clr = 1'b0;
   endtask

   task automatic set_tab_all(input logic [31:0] v);
      for (int i = 0; i < 8; i++) rnd_tab[i] = v;
   endtask

   // Runs one generation: vmode 0 = rnd_valid always 1, 1 = toggling.
   task automatic drive_run(input int vmode, output logic saw_done,
                            output logic wok, output logic wok0);
      int   acc;
      logic hs_p;
      acc = 0; saw_done = 1'b0; wok = 1'b0; wok0 = 1'b1;
      start = 1'b1;
      bus.rnd_valid = 1'b0;
      bus.rnd_data = rnd_tab[0];
      for (int cyc = 0; cyc < 200 && !saw_done; cyc++) begin
         @(negedge clk);
         hs_p = bus.rnd_valid && bus.rnd_ready;
         @(posedge clk);
         #1;
         if (!hold_start) start = 1'b0;
         if (cyc == 0) wok0 = weight_ok;
         if (hs_p) acc++;
         bus.rnd_data  = rnd_tab[acc % 8];
         bus.rnd_valid = (vmode == 0) ? 1'b1 : cyc[0];
         if (done) begin
            saw_done = 1'b1;
            wok = weight_ok;
         end
      end
      checks++;
      if (saw_done !== 1'b1) begin
         errors++;
         $display("FAIL run_timeout: done=%0b required 1 within 200 cycles", saw_done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; bus.rnd_valid = 1'b0; bus.rnd_data = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, weight_ok} !== 3'b000) begin
         errors++; $display("FAIL reset_status: got %b required 000", {busy, done, weight_ok});
      end
      checks++;
      if ({bus.rnd_ready, bus.mem_we, bus.sort_start, bus.coef_valid} !== 4'b0000) begin
         errors++; $display("FAIL reset_strobes: got %b required 0000",
                            {bus.rnd_ready, bus.mem_we, bus.sort_start, bus.coef_valid});
      end
      checks++;
      if (bus.mem_addr !== 10'h0 || bus.mem_wdata !== 32'h0) begin
         errors++; $display("FAIL reset_mem: addr=%h wdata=%h required 0", bus.mem_addr, bus.mem_wdata);
      end
      checks++;
      if ({bus.coef_data, bus.coef_idx} !== 12'h0) begin
         errors++; $display("FAIL reset_coef: got %h required 0", {bus.coef_data, bus.coef_idx});
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      logic sd, wok, wok0;
      logic [31:0] exp_w;
      logic [1:0]  exp_c;
      set_tab_all(32'hFFFF_FFFF);
      clear_mon();
      drive_run(0, sd, wok, wok0);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (wok !== 1'b1) begin errors++; $display("FAIL basic_weight_ok: got %b required 1", wok); end
      checks++;
      if (wr_cnt !== 8 || hs_cnt !== 8) begin
         errors++; $display("FAIL basic_counts: writes=%0d hs=%0d required 8/8", wr_cnt, hs_cnt);
      end
      for (int i = 0; i < 8; i++) begin
         exp_w = (i < 3) ? 32'hFFFF_FFFE : 32'hFFFF_FFFD;
         checks++;
         if (wr_addr[i] !== 10'(i) || wr_data[i] !== exp_w) begin
            errors++; $display("FAIL basic_write%0d: addr=%h data=%h required %h/%h",
                               i, wr_addr[i], wr_data[i], 10'(i), exp_w);
         end
      end
      checks++;
      if (sort_cnt !== 1 || done_cnt !== 1 || coef_cnt !== 8) begin
         errors++; $display("FAIL basic_pulses: sort=%0d done=%0d coef=%0d required 1/1/8",
                            sort_cnt, done_cnt, coef_cnt);
      end
      for (int i = 0; i < 8; i++) begin
         exp_c = (i < 3) ? 2'b01 : 2'b00;
         checks++;
         if (coef_arr[i] !== exp_c || coef_seq[i] !== 10'(i)) begin
            errors++; $display("FAIL basic_coef%0d: data=%b idx=%0d required %b/%0d",
                               i, coef_arr[i], coef_seq[i], exp_c, i);
         end
      end
      checks++;
      if (align_err !== 0) begin errors++; $display("FAIL basic_align: got %0d required 0", align_err); end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, weight_ok} !== 3'b001) begin
         errors++; $display("FAIL basic_hold: busy/done/wok=%b required 001", {busy, done, weight_ok});
      end
   endtask

   task automatic test_negative();
      logic sd, wok, wok0;
      logic [1:0] exp_c;
      set_tab_all(32'h0000_0000);
      clear_mon();
      drive_run(0, sd, wok, wok0);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (wok0 !== 1'b0) begin errors++; $display("FAIL neg_wok_clear: got %b required 0", wok0); end
      checks++;
      if (wok !== 1'b1) begin errors++; $display("FAIL neg_weight_ok: got %b required 1", wok); end
      for (int i = 0; i < 8; i++) begin
         exp_c = (i < 3) ? 2'b11 : 2'b00;
         checks++;
         if (coef_arr[i] !== exp_c || wr_data[i] !== ((i < 3) ? 32'h0 : 32'h1)) begin
            errors++; $display("FAIL neg_coef%0d: coef=%b wdata=%h required %b", i, coef_arr[i], wr_data[i], exp_c);
         end
      end
   endtask

   task automatic test_illegal(input logic [1:0] val);
      logic sd, wok, wok0;
      logic [1:0] exp4;
      exp4 = (val == 2'b11) ? 2'b00 : 2'b01;
      set_tab_all(32'hFFFF_FFFF);
      corrupt_en = 1'b1; corrupt_val = val;
      clear_mon();
      drive_run(0, sd, wok, wok0);
      corrupt_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (coef_arr[4] !== exp4 || coef_arr[0] !== 2'b01 || coef_arr[3] !== 2'b00) begin
         errors++; $display("FAIL corrupt%b_coef: idx4=%b idx0=%b idx3=%b required %b/01/00",
                            val, coef_arr[4], coef_arr[0], coef_arr[3], exp4);
      end
      checks++;
      if (wok !== 1'b0 || weight_ok !== 1'b0) begin
         errors++; $display("FAIL corrupt%b_weight_ok: got %b/%b required 0", val, wok, weight_ok);
      end
   endtask

   task automatic test_mixed_toggle();
      logic sd, wok, wok0;
      logic [31:0] exp_w [8];
      logic [1:0]  exp_c [8];
      rnd_tab[0] = 32'hFFFF_FFFF; rnd_tab[1] = 32'h0000_0000;
      rnd_tab[2] = 32'hDEAD_BEEF; rnd_tab[3] = 32'h1234_5678;
      rnd_tab[4] = 32'h0000_0003; rnd_tab[5] = 32'hAAAA_AAAA;
      rnd_tab[6] = 32'h5555_5555; rnd_tab[7] = 32'h8000_0000;
      exp_w[0] = 32'hFFFF_FFFE; exp_w[1] = 32'h0000_0000;
      exp_w[2] = 32'hDEAD_BEEE; exp_w[3] = 32'h1234_5679;
      exp_w[4] = 32'h0000_0001; exp_w[5] = 32'hAAAA_AAA9;
      exp_w[6] = 32'h5555_5555; exp_w[7] = 32'h8000_0001;
      exp_c[0] = 2'b01; exp_c[1] = 2'b11; exp_c[2] = 2'b01; exp_c[3] = 2'b00;
      exp_c[4] = 2'b00; exp_c[5] = 2'b00; exp_c[6] = 2'b00; exp_c[7] = 2'b00;
      clear_mon();
      drive_run(1, sd, wok, wok0);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (wr_cnt !== 8 || hs_cnt !== 8 || align_err !== 0) begin
         errors++; $display("FAIL toggle_counts: writes=%0d hs=%0d align=%0d required 8/8/0",
                            wr_cnt, hs_cnt, align_err);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (wr_addr[i] !== 10'(i) || wr_data[i] !== exp_w[i] || coef_arr[i] !== exp_c[i]) begin
            errors++; $display("FAIL toggle_word%0d: addr=%h data=%h coef=%b required %h/%h/%b",
                               i, wr_addr[i], wr_data[i], coef_arr[i], 10'(i), exp_w[i], exp_c[i]);
         end
      end
      checks++;
      if (wok !== 1'b1) begin errors++; $display("FAIL toggle_weight_ok: got %b required 1", wok); end
   endtask

   task automatic test_reset_sort_wait();
      logic sd, wok, wok0;
      logic reached;
      sorter_en = 1'b0;
      set_tab_all(32'hFFFF_FFFF);
      clear_mon();
      start = 1'b1; bus.rnd_valid = 1'b1; bus.rnd_data = 32'hFFFF_FFFF;
      reached = 1'b0;
      for (int c = 0; c < 60 && !reached; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (sort_cnt == 1) reached = 1'b1;
      end
      checks++;
      if (reached !== 1'b1) begin errors++; $display("FAIL rsw_reach: sort_start seen=%b required 1", reached); end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; start = 1'b0;
      checks++;
      if ({busy, bus.sort_start, bus.rnd_ready, bus.mem_we, bus.coef_valid, done} !== 6'b0) begin
         errors++; $display("FAIL rsw_outputs: busy/ss/rdy/we/cv/done=%b required 000000",
                            {busy, bus.sort_start, bus.rnd_ready, bus.mem_we, bus.coef_valid, done});
      end
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rsw_idle: busy=%b required 0", busy); end
      sorter_en = 1'b1;
      clear_mon();
      drive_run(0, sd, wok, wok0);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (wok !== 1'b1 || wr_cnt !== 8 || sort_cnt !== 1 || coef_cnt !== 8) begin
         errors++; $display("FAIL rsw_rerun: wok=%b writes=%0d sort=%0d coef=%0d required 1/8/1/8",
                            wok, wr_cnt, sort_cnt, coef_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic sd1, sd2, wok1, wok2, wok0;
      set_tab_all(32'hFFFF_FFFF);
      hold_start = 1'b1;
      clear_mon();
      drive_run(0, sd1, wok1, wok0);
      drive_run(0, sd2, wok2, wok0);
      hold_start = 1'b0;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (done_cnt !== 2 || sort_cnt !== 2 || busy !== 1'b0) begin
         errors++; $display("FAIL b2b_runs: done=%0d sort=%0d busy=%b required 2/2/0",
                            done_cnt, sort_cnt, busy);
      end
      checks++;
      if (hs_cnt !== 16 || wr_cnt !== 16 || coef_cnt !== 16) begin
         errors++; $display("FAIL b2b_counts: hs=%0d writes=%0d coef=%0d required 16/16/16",
                            hs_cnt, wr_cnt, coef_cnt);
      end
      checks++;
      if (wok1 !== 1'b1 || wok2 !== 1'b1) begin
         errors++; $display("FAIL b2b_weight_ok: got %b/%b required 1/1", wok1, wok2);
      end
   endtask

   initial begin
      sorter_en = 1'b1; corrupt_en = 1'b0; corrupt_val = 2'b00;
      hold_start = 1'b0; mon_clr = 1'b1;
      rst = 1'b1; start = 1'b0; bus.rnd_valid = 1'b0; bus.rnd_data = 32'h0;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      test_reset();
      test_basic();
      test_negative();
      test_illegal(2'b11);
      test_mixed_toggle();
      test_illegal(2'b10);
      test_reset_sort_wait();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/spoly_gen_ctrl.md
SPOLY_GEN_CTRL -- requirements
Module: spoly_gen_ctrl

Interface
REQ-001 The block SHALL have parameter P, default 677, giving the number of polynomial coefficients.
REQ-002 The block SHALL have parameter W, default 254, giving the required Hamming weight (1 <= W <= P).
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the random and memory word width.
REQ-004 The block SHALL have parameter ADDR_W, default 10, giving the memory address width (2^ADDR_W >= P).
REQ-005 The block SHALL have these ports, one per line:
  clk  in  1  single clock; all logic on its rising edge
  rst  in  1  synchronous, active-high reset
  start  in  1  request one generation run; sampled only in IDLE
  busy  out  1  high from FILL entry until DONE exit
  done  out  1  one-cycle pulse in DONE
  weight_ok  out  1  valid when done=1: emitted nonzero count == W and no illegal codes
  rnd_data  in  DATA_W  random word
  rnd_valid  in  1  rnd_data valid
  rnd_ready  out  1  block accepts rnd_data
  mem_we  out  1  working-memory write strobe
  mem_addr  out  ADDR_W  working-memory address (read and write)
  mem_wdata  out  DATA_W  working-memory write data
  mem_rdata  in  DATA_W  read data, 1-cycle latency after mem_addr
  sort_start  out  1  one-cycle pulse to the external sorter
  sort_done  in  1  sorter-finished pulse or level
  coef_valid  out  1  coef_data valid strobe
  coef_data  out  2  coefficient, two's complement in {-1,0,+1}
  coef_idx  out  ADDR_W  index of coef_data

Function
REQ-006 The FSM SHALL have states IDLE, FILL, SORT_KICK, SORT_WAIT, DRAIN, DONE.
REQ-007 IDLE -> FILL when start=1; start SHALL be ignored in every other state.
REQ-008 In FILL, rnd_ready SHALL be 1; a word is accepted on each cycle where rnd_valid&rnd_ready=1; index i counts 0..P-1.
REQ-009 For accepted word r at index i: i<W -> mem_wdata={r[DATA_W-1:1],1'b0}; i>=W -> mem_wdata={r[DATA_W-1:2],2'b01}.
REQ-010 mem_we/mem_addr/mem_wdata SHALL be registered: the write appears the cycle after acceptance, mem_addr=i.
REQ-011 rnd_valid=0 in FILL SHALL stall with no write and no index change.
REQ-012 After acceptance of index P-1: rnd_ready SHALL drop next cycle; FILL -> SORT_KICK once the last write has been issued.
REQ-013 SORT_KICK SHALL assert sort_start for exactly one cycle, then go to SORT_WAIT.
REQ-014 SORT_WAIT SHALL hold all memory outputs low/stable until sort_done=1, then go to DRAIN; sort_done outside SORT_WAIT SHALL be ignored.
REQ-015 DRAIN SHALL issue reads at addresses 0..P-1, one per cycle with mem_we=0, then wait one extra cycle for the last read.
REQ-016 For each returned word d (one cycle after its address): coef_valid=1, coef_idx=address, coef_data = d[1:0]==00 -> 2'b11 (-1), 01 -> 2'b00, 10 -> 2'b01 (+1).
REQ-017 d[1:0]==11 SHALL emit coef_data=2'b00 and set a sticky illegal flag for the run.
REQ-018 A nonzero counter (ceil(log2(P+1)) bits, no wrap) SHALL count emitted +1/-1 coefficients.
REQ-019 After the last coefficient: DRAIN -> DONE; in DONE, done=1 and weight_ok=(count==W)&~illegal for one cycle; next state IDLE.
REQ-020 weight_ok SHALL hold its value until the next start is accepted, then clear.
REQ-021 Counters and the illegal flag SHALL clear on entry to FILL.
REQ-022 Exactly P rnd handshakes, P writes, P reads and P coef_valid pulses SHALL occur per run.

Reset
REQ-023 rst=1 at any clock edge, including mid-run, SHALL force IDLE, zero counters and flag, and drive every output to 0 on the following cycle.
REQ-024 rst SHALL take priority over start, rnd_valid and sort_done in the same cycle.

Verification
REQ-025 P=8,W=3, rnd_valid always 1, rnd_data=0xFFFFFFFF -> writes addr0..2=0xFFFFFFFE, addr3..7=0xFFFFFFFD; one sort_start pulse.
REQ-026 Same run, sorter model leaves memory unchanged -> coef_data 01,01,01,00x5; done=1, weight_ok=1.
REQ-027 rnd_valid toggling 1,0,1,0 -> exactly 8 writes, addresses 0..7 in order, no write on stall cycles.
REQ-028 Memory word with low bits 11 at addr 4 during DRAIN -> coef_data 00 at idx 4, weight_ok=0.
REQ-029 rst pulsed in SORT_WAIT -> next cycle busy=0, sort_start=0, rnd_ready=0; a new start runs a clean full sequence.
REQ-030 start held high through a run -> exactly one run per start sampled in IDLE; done pulses once per run.
